// File: rtl/mb_dff_reg_pkg.sv
// Shared types and helpers for the mb_dff_reg storage element.
// Control decode follows the rising-edge priority: reset, both-asserted, clear, set, load.
package mb_dff_reg_pkg;

   typedef enum logic [2:0] {
      CTL_RST  = 3'd0,
      CTL_BOTH = 3'd1,
      CTL_CLR  = 3'd2,
      CTL_SET  = 3'd3,
      CTL_LOAD = 3'd4
   } ctl_e;

   // Both-asserted output value, per bit (Q and Qn are both high).
   localparam logic BOTH_Q  = 1'b1;
   localparam logic BOTH_QN = 1'b1;

   function automatic ctl_e decode_ctl(input logic rst, input logic sn, input logic rn);
      ctl_e ctl;
      if (rst)
         ctl = CTL_RST;
      else if (!sn && !rn)
         ctl = CTL_BOTH;
      else if (!rn)
         ctl = CTL_CLR;
      else if (!sn)
         ctl = CTL_SET;
      else
         ctl = CTL_LOAD;
      return ctl;
   endfunction

endpackage

// File: rtl/mb_dff_reg_if.sv
// Data and set/clear bundle for mb_dff_reg; clock and reset stay as plain ports.
// Handshake: none -- every rising Cp edge captures; Sn/Rn/D are sampled, Q/Qn are registered.
interface mb_dff_reg_if #(
   parameter int WIDTH = 1
);
   logic             Sn;
   logic             Rn;
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] Qn;

   modport master (
      output Sn,
      output Rn,
      output D,
      input  Q,
      input  Qn
   );

   modport slave (
      input  Sn,
      input  Rn,
      input  D,
      output Q,
      output Qn
   );
endinterface

// File: rtl/mb_dff_bit.sv
// One master-slave D flip-flop bit with synchronous reset, active-low set/clear.
// The master/slave latch pair is written as its equivalent rising-edge capture.
module mb_dff_bit
   import mb_dff_reg_pkg::*;
(
   input  logic i_cp,
   input  logic i_rst,
   input  logic i_sn,
   input  logic i_rn,
   input  logic i_d,
   output logic o_q,
   output logic o_qn
);

   ctl_e w_ctl;
   logic r_q;
   logic r_qn;

   assign w_ctl = decode_ctl(i_rst, i_sn, i_rn);

   // Qn is its own register so the both-asserted state (Q=Qn=1) can be held.
   always_ff @(posedge i_cp) begin
      case (w_ctl)
         CTL_RST: begin
            r_q  <= 1'b0;
            r_qn <= 1'b1;
         end
         CTL_BOTH: begin
            r_q  <= BOTH_Q;
            r_qn <= BOTH_QN;
         end
         CTL_CLR: begin
            r_q  <= 1'b0;
            r_qn <= 1'b1;
         end
         CTL_SET: begin
            r_q  <= 1'b1;
            r_qn <= 1'b0;
         end
         default: begin
            r_q  <= i_d;
            r_qn <= ~i_d;
         end
      endcase
   end

   assign o_q  = r_q;
   assign o_qn = r_qn;

endmodule

// File: rtl/mb_dff_reg.sv
// WIDTH-bit register of mb_dff_bit cells sharing clock, reset and set/clear.
// The top only fans out controls and gathers the per-bit Q/Qn.
module mb_dff_reg
   import mb_dff_reg_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic         Cp,
   input  logic         rst,
   mb_dff_reg_if.slave  bus
);

   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_qn;

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      mb_dff_bit u_bit (
         .i_cp  (Cp),
         .i_rst (rst),
         .i_sn  (bus.Sn),
         .i_rn  (bus.Rn),
         .i_d   (bus.D[g]),
         .o_q   (w_q[g]),
         .o_qn  (w_qn[g])
      );
   end

   assign bus.Q  = w_q;
   assign bus.Qn = w_qn;

endmodule

// File: tb/tb_mb_dff_reg.sv
// Directed plus randomized bench for mb_dff_reg at WIDTH=4.
// Expected Q/Qn come from a priority-list model evaluated on the values present at each edge.
module tb_mb_dff_reg;

   localparam int W = 4;

   logic Cp = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   logic [W-1:0] exp_q;
   logic [W-1:0] exp_qn;

   mb_dff_reg_if #(.WIDTH(W)) tif ();

   mb_dff_reg #(.WIDTH(W)) dut (
      .Cp  (Cp),
      .rst (rst),
      .bus (tif)
   );

   always #50 Cp = ~Cp;

   // Reference: the outcome of one rising edge given the inputs present at it.
   function automatic void ref_edge(input logic r, input logic sn, input logic rn,
                                    input logic [W-1:0] d);
      if (r) begin
         exp_q = '0; exp_qn = '1;
      end else if (sn == 1'b0 && rn == 1'b0) begin
         exp_q = '1; exp_qn = '1;
      end else if (rn == 1'b0) begin
         exp_q = '0; exp_qn = '1;
      end else if (sn == 1'b0) begin
         exp_q = '1; exp_qn = '0;
      end else begin
         exp_q = d; exp_qn = ~d;
      end
   endfunction

   task automatic check(input string tag);
      tests++;
      assert (tif.Q === exp_q) else begin
         fails++;
         $error("FAIL %s Q got %h expected %h", tag, tif.Q, exp_q);
      end
      tests++;
      assert (tif.Qn === exp_qn) else begin
         fails++;
         $error("FAIL %s Qn got %h expected %h", tag, tif.Qn, exp_qn);
      end
   endtask

   // Drive at the falling edge (after confirming the outputs held), check 1 ns after the rise.
   task automatic step(input string tag, input logic r, input logic sn, input logic rn,
                       input logic [W-1:0] d, input logic hold_chk);
      @(negedge Cp);
      if (hold_chk) check({tag, "_hold"});
      rst    = r;
      tif.Sn = sn;
      tif.Rn = rn;
      tif.D  = d;
      ref_edge(r, sn, rn, d);
      @(posedge Cp);
      #1;
      check(tag);
   endtask

   initial begin
      logic [W-1:0] v;
      logic         rr, ss, cc;
      rst = 1'b1; tif.Sn = 1'b0; tif.Rn = 1'b0; tif.D = '0;

      // Reset wins over both-asserted controls.
      step("reset0", 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
      step("reset1", 1'b1, 1'b0, 1'b0, 4'h0, 1'b1);

      step("both", 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
      step("both_exit_load", 1'b0, 1'b1, 1'b1, 4'h6, 1'b1);

      step("clr_d0a", 1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
      step("clr_d0b", 1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
      step("clr_d1a", 1'b0, 1'b1, 1'b0, 4'hF, 1'b1);
      step("clr_d1b", 1'b0, 1'b1, 1'b0, 4'hF, 1'b1);

      step("set_d0a", 1'b0, 1'b0, 1'b1, 4'h0, 1'b1);
      step("set_d0b", 1'b0, 1'b0, 1'b1, 4'h0, 1'b1);
      step("set_d1a", 1'b0, 1'b0, 1'b1, 4'hF, 1'b1);
      step("set_d1b", 1'b0, 1'b0, 1'b1, 4'hF, 1'b1);

      step("load0a", 1'b0, 1'b1, 1'b1, 4'h0, 1'b1);
      step("load0b", 1'b0, 1'b1, 1'b1, 4'h0, 1'b1);
      step("load1", 1'b0, 1'b1, 1'b1, 4'hF, 1'b1);
      step("load_a", 1'b0, 1'b1, 1'b1, 4'hA, 1'b1);

      // Short Sn pulse while Cp is high must not disturb the stored value.
      #10 tif.Sn = 1'b0;
      #20 tif.Sn = 1'b1;
      #1 check("sn_pulse");

      // D glitch while Cp is high must not reach the outputs.
      step("glitch_pre", 1'b0, 1'b1, 1'b1, 4'h5, 1'b1);
      #10 tif.D = 4'hA;
      #10 tif.D = 4'h5;
      #1 check("d_glitch");

      // Reset mid-operation, then captures resume.
      step("mid_rst", 1'b1, 1'b0, 1'b1, 4'h9, 1'b1);
      step("post_rst", 1'b0, 1'b1, 1'b1, 4'h9, 1'b1);

      for (int i = 0; i < 60; i++) begin
         rr = ($urandom_range(0, 9) == 0);
         ss = ($urandom_range(0, 3) != 0);
         cc = ($urandom_range(0, 3) != 0);
         v  = W'($urandom);
         step("rand", rr, ss, cc, v, 1'b1);
      end

      @(negedge Cp);
      check("final_hold");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
